// File: rtl/mem_stage_access.sv
// mem_stage_access
// MEM-stage data memory access controller of the LC-3b pipeline. It decodes the
// EX/MEM control word and sequences word, byte and indirect reads and writes over
// the mem_* request/response handshake. It stalls the upstream latches while an
// access is outstanding and registers load data for MEM/WB.
// Build option: define MEM_ALIGN_CHECK_EN to trap misaligned word accesses. A
// trapped access produces an align_err pulse and no memory request. Without the
// option, bit 0 of a word address is simply cleared.
//
// state | meaning
// IDLE  | decode CW_in; launch pointer fetch or data access
// PTR   | indirect pointer read outstanding
// ACC   | data read/write outstanding
// ERR   | misaligned word access trapped (MEM_ALIGN_CHECK_EN only)
module mem_stage_access #(
  parameter int CW_READ_BIT  = 0,
  parameter int CW_WRITE_BIT = 1,
  parameter int CW_BYTE_BIT  = 2,
  parameter int CW_IND_BIT   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR_in,
  input  logic [15:0] PC_in,
  input  logic [15:0] ALU_in,
  input  logic [15:0] CW_in,
  input  logic [15:0] store_data,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_en,
  output logic [15:0] mdr_out,
  output logic        stall,
  output logic        align_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PTR  = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
`ifdef MEM_ALIGN_CHECK_EN
  localparam logic [1:0] S_ERR  = 2'd3;
`endif

  logic [1:0]  state_q, state_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [15:0] mem_address_q, mem_address_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_byte_en_q, mem_byte_en_d;
  logic [15:0] mdr_q, mdr_d;

  logic        rd_c, wr_c, byte_c, ind_c, req_c;
  logic [15:0] ea_c, acc_addr_c, acc_wdata_c, load_data_c;
  logic [1:0]  acc_be_c;
  logic        go_acc;
  logic        unused_ok;

`ifdef MEM_ALIGN_CHECK_EN
  logic        mis_c, trap;
  logic        align_err_q, align_err_d;
`endif

  // Read wins when both read and write bits are set (illegal encoding)
  assign rd_c   = CW_in[CW_READ_BIT];
  assign wr_c   = CW_in[CW_WRITE_BIT] & ~CW_in[CW_READ_BIT];
  assign req_c  = CW_in[CW_READ_BIT] | CW_in[CW_WRITE_BIT];
  assign byte_c = CW_in[CW_BYTE_BIT];
  assign ind_c  = CW_in[CW_IND_BIT];

  // IR/PC ride along the pipeline and take no part in access control
  assign unused_ok = ^{IR_in, PC_in, CW_in};

  // Effective address: the fetched pointer when leaving PTR, else the ALU result
  assign ea_c        = (state_q == S_PTR) ? mem_rdata : ALU_in;
  assign acc_addr_c  = byte_c ? ea_c : {ea_c[15:1], 1'b0};
  assign acc_wdata_c = byte_c ? {store_data[7:0], store_data[7:0]} : store_data;
  assign acc_be_c    = ~wr_c ? 2'b00 : (~byte_c ? 2'b11 : (ea_c[0] ? 2'b10 : 2'b01));
  assign load_data_c = ~byte_c ? mem_rdata
                               : {8'h00, (mem_address_q[0] ? mem_rdata[15:8] : mem_rdata[7:0])};

`ifdef MEM_ALIGN_CHECK_EN
  assign mis_c = ~byte_c & ea_c[0];
`endif

  // Hold upstream latches while decoding a request or waiting on memory;
  // the completion cycle releases them so the next instruction loads
  assign stall = ~reset & (((state_q == S_IDLE) & req_c) |
                           (state_q == S_PTR) |
                           ((state_q == S_ACC) & ~mem_resp));

  // Next-state and registered request/data computation
  always_comb begin
    state_d       = state_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_byte_en_d = mem_byte_en_q;
    mdr_d         = mdr_q;
    go_acc        = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    trap          = 1'b0;
    align_err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_c && ind_c) begin
          state_d       = S_PTR;
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_byte_en_d = 2'b00;
          mem_address_d = {ALU_in[15:1], 1'b0};
        end else if (req_c) begin
`ifdef MEM_ALIGN_CHECK_EN
          if (mis_c) trap = 1'b1;
          else       go_acc = 1'b1;
`else
          go_acc = 1'b1;
`endif
        end
      end
      S_PTR: begin
        if (mem_resp) begin
`ifdef MEM_ALIGN_CHECK_EN
          if (mis_c) trap = 1'b1;
          else       go_acc = 1'b1;
`else
          go_acc = 1'b1;
`endif
        end
      end
      S_ACC: begin
        if (mem_resp) begin
          state_d       = S_IDLE;
          mem_read_d    = 1'b0;
          mem_write_d   = 1'b0;
          mem_byte_en_d = 2'b00;
          if (mem_read_q) mdr_d = load_data_c;
        end
      end
`ifdef MEM_ALIGN_CHECK_EN
      S_ERR: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase

    if (go_acc) begin
      state_d       = S_ACC;
      mem_read_d    = rd_c;
      mem_write_d   = wr_c;
      mem_address_d = acc_addr_c;
      mem_byte_en_d = acc_be_c;
      if (wr_c) mem_wdata_d = acc_wdata_c;
    end

`ifdef MEM_ALIGN_CHECK_EN
    if (trap) begin
      state_d       = S_ERR;
      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
      mem_byte_en_d = 2'b00;
      align_err_d   = 1'b1;
      if (rd_c) mdr_d = 16'h0000;
    end
`endif
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= 16'h0000;
      mem_wdata_q   <= 16'h0000;
      mem_byte_en_q <= 2'b00;
      mdr_q         <= 16'h0000;
`ifdef MEM_ALIGN_CHECK_EN
      align_err_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_byte_en_q <= mem_byte_en_d;
      mdr_q         <= mdr_d;
`ifdef MEM_ALIGN_CHECK_EN
      align_err_q   <= align_err_d;
`endif
    end
  end

  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_byte_en = mem_byte_en_q;
  assign mdr_out     = mdr_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign align_err   = align_err_q;
`else
  assign align_err   = 1'b0;
`endif

endmodule
